traffic_light_controller_actuated: RTL
======================================

Name: traffic_light_controller_actuated

Overview:
- Parametrised, sensor-actuated successor to the fixed-time two-way intersection controller.
- Adds configurable phase durations, a mandatory all-red clearance interval, vehicle-demand gap-out between min and max green, latched pedestrian requests with walk signals, and a flashing night mode.
- Drives the NS and EW signal heads directly; sensors and push-buttons are synchronised upstream.

Parameters:
- TIMER_W, 8, width of the phase elapsed counter; must hold GREEN_MAX-1.
- GREEN_MIN, 4, minimum green cycles (>=1).
- GREEN_MAX, 10, maximum green cycles (>=GREEN_MIN).
- YELLOW_TIME, 2, yellow cycles (>=1).
- ALLRED_TIME, 1, all-red clearance cycles (>=1).
- PED_WALK_TIME, 3, walk cycles at start of a served green (1..GREEN_MIN).
- FLASH_HALF, 2, cycles per on/off half-period in flash mode (>=1).

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ns_car  in  1  NS vehicle present (level).
- ew_car  in  1  EW vehicle present (level).
- ns_ped_req  in  1  NS-parallel crossing request (pulse, latched).
- ew_ped_req  in  1  EW-parallel crossing request (pulse, latched).
- flash_mode  in  1  night flash request (level).
- NS  out  3  {Red, Yellow, Green}.
- EW  out  3  {Red, Yellow, Green}.
- ns_walk  out  1  NS walk lamp.
- ew_walk  out  1  EW walk lamp.
- phase  out  3  current state encoding (for debug/status).

Behaviour:
- States and phase codes: NS_GREEN=0, NS_YELLOW=1, NS_ALLRED=2, EW_GREEN=3, EW_YELLOW=4, EW_ALLRED=5, FLASH=6.
- Moore outputs decoded from registered state, elapsed counter and flags only. There is no combinational path from inputs to outputs.
- Elapsed counter clears to 0 on every state entry and increments by 1 per cycle while in the state. A state "lasting D cycles" exits on the edge where elapsed==D-1.
- Demand definitions:
  - NS green uses cross_demand = ew_car | ew_ped_pending.
  - EW green uses cross_demand = ns_car | ns_ped_pending.
- Green exit: when (elapsed>=GREEN_MIN-1 and cross_demand) or elapsed==GREEN_MAX-1. Green always lasts between GREEN_MIN and GREEN_MAX cycles.
- Yellow lasts YELLOW_TIME cycles, then goes to the matching ALLRED.
- NS_ALLRED / EW_ALLRED last ALLRED_TIME cycles. At exit: FLASH if flash_mode==1, else EW_GREEN / NS_GREEN respectively.
- FLASH:
  - flash_on starts at 1 and toggles every FLASH_HALF cycles.
  - NS = flash_on ? 010 : 000; EW = flash_on ? 100 : 000; walks 0.
  - The first cycle with flash_mode==0 exits to EW_ALLRED, so all-red is always shown before NS_GREEN.
- Signal head encoding: NS_GREEN -> NS=001, EW=100; NS_YELLOW -> 010/100; EW_GREEN -> 100/001; EW_YELLOW -> 100/010; both ALLRED states -> 100/100.
- Pedestrian requests:
  - x_ped_req sets x_ped_pending (sticky).
  - On the edge entering x_GREEN, x_walk_active <= x_ped_pending | x_ped_req and x_ped_pending clears. A request coincident with the entry edge is served, not left pending.
  - A request arriving during its own green latches for the next same-direction green.
  - Pending requests are retained through FLASH.
- x_walk = 1 while state==x_GREEN and x_walk_active and elapsed<PED_WALK_TIME; 0 otherwise.
- Only FLASH and the ALLRED-exit decision look at flash_mode. Asserting it mid-green completes the current green/yellow/all-red sequence first.
- Reset (async assert, any state):
  - state=NS_GREEN, elapsed=0, both pendings and walk_active flags=0, flash_on=1.
  - Outputs NS=001, EW=100, ns_walk=0, ew_walk=0, phase=0.
  - Reset release is used synchronously.

Test Plan:
- Reset, all inputs 0 -> NS green 10 cycles, NS yellow 2, all-red 1, EW green 10, EW yellow 2, all-red 1; period 26 cycles, repeating.
- ew_car=1 from reset -> NS green exits after exactly 4 cycles (GREEN_MIN). With ns_car=0 afterwards, EW green lasts 10 cycles.
- ns_ped_req 1-cycle pulse in cycle 3 of EW green -> next NS green has ns_walk=1 for its first 3 cycles then 0; a second NS green with no request has ns_walk=0 throughout.
- ew_ped_req pulsed on the exact edge entering EW_GREEN -> ew_walk=1 for 3 cycles in that green; ew_ped_pending=0 afterwards.
- flash_mode=1 asserted at NS green cycle 2 -> NS green/yellow/all-red complete (10/2/1), then FLASH with NS toggling 010,010,000,000 and EW 100,100,000,000. Deassert flash_mode -> 1 cycle all-red (100/100) then NS green.
- reset_n low during EW yellow with ns_ped_pending=1 -> same cycle NS=001, EW=100, phase=0; after release, NS green has ns_walk=0.

Source files
------------

// File: rtl/traffic_light_controller_actuated.sv
// traffic_light_controller_actuated: actuated two-way intersection controller with gap-out, all-red clearance, ped walk and night flash
module traffic_light_controller_actuated #(
  parameter int TIMER_W       = 8,
  parameter int GREEN_MIN     = 4,
  parameter int GREEN_MAX     = 10,
  parameter int YELLOW_TIME   = 2,
  parameter int ALLRED_TIME   = 1,
  parameter int PED_WALK_TIME = 3,
  parameter int FLASH_HALF    = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ns_car,
  input  logic       ew_car,
  input  logic       ns_ped_req,
  input  logic       ew_ped_req,
  input  logic       flash_mode,
  output logic [2:0] NS,
  output logic [2:0] EW,
  output logic       ns_walk,
  output logic       ew_walk,
  output logic [2:0] phase
);
  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    NS_ALLRED = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    EW_ALLRED = 3'd5,
    FLASH     = 3'd6
  } state_t;
  localparam logic [TIMER_W-1:0] G_MIN = TIMER_W'(GREEN_MIN - 1);
  localparam logic [TIMER_W-1:0] G_MAX = TIMER_W'(GREEN_MAX - 1);
  localparam logic [TIMER_W-1:0] Y_END = TIMER_W'(YELLOW_TIME - 1);
  localparam logic [TIMER_W-1:0] R_END = TIMER_W'(ALLRED_TIME - 1);
  localparam logic [TIMER_W-1:0] F_END = TIMER_W'(FLASH_HALF - 1);
  localparam logic [TIMER_W-1:0] WALK  = TIMER_W'(PED_WALK_TIME);
  state_t state_q, state_d;
  logic [TIMER_W-1:0] elapsed_q, elapsed_d;
  logic ns_pend_q, ns_pend_d, ew_pend_q, ew_pend_d;
  logic ns_act_q, ns_act_d, ew_act_q, ew_act_d;
  logic flash_on_q, flash_on_d;
  logic enter, ns_enter, ew_enter, half_end;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      NS_GREEN:  if ((elapsed_q >= G_MIN && (ew_car | ew_pend_q)) || elapsed_q == G_MAX) state_d = NS_YELLOW;
      NS_YELLOW: if (elapsed_q == Y_END) state_d = NS_ALLRED;
      NS_ALLRED: if (elapsed_q == R_END) state_d = flash_mode ? FLASH : EW_GREEN;
      EW_GREEN:  if ((elapsed_q >= G_MIN && (ns_car | ns_pend_q)) || elapsed_q == G_MAX) state_d = EW_YELLOW;
      EW_YELLOW: if (elapsed_q == Y_END) state_d = EW_ALLRED;
      EW_ALLRED: if (elapsed_q == R_END) state_d = flash_mode ? FLASH : NS_GREEN;
      FLASH:     if (!flash_mode) state_d = EW_ALLRED;
      default:   state_d = NS_GREEN;
    endcase
    enter    = state_d != state_q;
    ns_enter = enter && state_d == NS_GREEN;
    ew_enter = enter && state_d == EW_GREEN;
    // in FLASH the elapsed counter doubles as the half-period timer
    half_end   = state_q == FLASH && !enter && elapsed_q == F_END;
    elapsed_d  = (enter || half_end) ? '0 : elapsed_q + 1'b1;
    flash_on_d = (enter && state_d == FLASH) ? 1'b1 : half_end ? ~flash_on_q : flash_on_q;
    ns_pend_d  = ns_enter ? 1'b0 : ns_pend_q | ns_ped_req;
    ew_pend_d  = ew_enter ? 1'b0 : ew_pend_q | ew_ped_req;
    ns_act_d   = ns_enter ? ns_pend_q | ns_ped_req : ns_act_q;
    ew_act_d   = ew_enter ? ew_pend_q | ew_ped_req : ew_act_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= NS_GREEN;
      elapsed_q  <= '0;
      ns_pend_q  <= 1'b0;
      ew_pend_q  <= 1'b0;
      ns_act_q   <= 1'b0;
      ew_act_q   <= 1'b0;
      flash_on_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      elapsed_q  <= elapsed_d;
      ns_pend_q  <= ns_pend_d;
      ew_pend_q  <= ew_pend_d;
      ns_act_q   <= ns_act_d;
      ew_act_q   <= ew_act_d;
      flash_on_q <= flash_on_d;
    end
  end
  always_comb begin
    NS = 3'b100;
    EW = 3'b100;
    unique case (state_q)
      NS_GREEN:  NS = 3'b001;
      NS_YELLOW: NS = 3'b010;
      EW_GREEN:  EW = 3'b001;
      EW_YELLOW: EW = 3'b010;
      FLASH: begin
        NS = flash_on_q ? 3'b010 : 3'b000;
        EW = flash_on_q ? 3'b100 : 3'b000;
      end
      default: ;
    endcase
    ns_walk = state_q == NS_GREEN && ns_act_q && elapsed_q < WALK;
    ew_walk = state_q == EW_GREEN && ew_act_q && elapsed_q < WALK;
    phase   = state_q;
  end
endmodule
